// File: rtl/pe_array_ins_issue_pkg.sv
// Shared constants and helpers for the PE array issue buffer.
// PE_ISSUE_REPEAT_EN adds a per-entry repeat count field.
package pe_array_ins_issue_pkg;

   localparam int DEF_PE_INS_WIDTH = 20;
   localparam logic [DEF_PE_INS_WIDTH-1:0] DEF_PE_NOP_INS = '0;
   localparam int SEL_WIDTH  = 3;
   localparam int PRED_WIDTH = 2;
   localparam int REP_WIDTH  = 4;

   typedef enum logic [1:0] {
      ISSUE_EMPTY,
      ISSUE_PARTIAL,
      ISSUE_FULL
   } issueState_e;

   // Buffer state is derived purely from occupancy; no separate state register.
   function automatic issueState_e issueState(input int unsigned count, input int unsigned depth);
      if (count == 0)
         return ISSUE_EMPTY;
      else if (count >= depth)
         return ISSUE_FULL;
      else
         return ISSUE_PARTIAL;
   endfunction

endpackage

// File: rtl/pe_array_ins_issue_fifo.sv
// Issue buffer storage: circular entry memory with read/write pointers and occupancy count.
module pe_issue_fifo #(
   parameter int WIDTH     = 25,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 3
) (
   input  logic                 iClk,
   input  logic                 iReset_n,
   input  logic                 iPush,
   input  logic                 iPop,
   input  logic                 iFlush,
   input  logic [WIDTH-1:0]     iWrData,
   output logic [WIDTH-1:0]     oHead,
   output logic [CNT_WIDTH-1:0] oCount
);

   localparam int PtrWidth = $clog2(DEPTH);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [PtrWidth-1:0]  wrPtr;
   logic [PtrWidth-1:0]  rdPtr;
   logic [CNT_WIDTH-1:0] count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (iFlush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (iPush)
            wrPtr <= wrPtr + 1'b1;
         if (iPop)
            rdPtr <= rdPtr + 1'b1;
         case ({iPush, iPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (iPush && !iFlush)
         mem[wrPtr] <= iWrData;
   end

   assign oHead  = mem[rdPtr];
   assign oCount = count;

endmodule

// File: rtl/pe_array_ins_issue.sv
// CP-to-PE-array issue buffer: queues decoded instructions and drives the PE IF stage,
// inserting NOPs when empty. PE_ISSUE_REPEAT_EN enables per-entry repeat issue.
module pe_array_ins_issue
   import pe_array_ins_issue_pkg::*;
#(
   parameter int INS_WIDTH  = DEF_PE_INS_WIDTH,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                  iClk,
   input  logic                  iReset_n,
   input  logic                  iCP_Issue_Valid,
   output logic                  oCP_Issue_Ready,
   input  logic [INS_WIDTH-1:0]  iCP_Issue_Instruction,
   input  logic [SEL_WIDTH-1:0]  iCP_Issue_Data_Sel,
   input  logic [PRED_WIDTH-1:0] iCP_Issue_Predication,
`ifdef PE_ISSUE_REPEAT_EN
   input  logic [REP_WIDTH-1:0]  iCP_Issue_Repeat,
`endif
   input  logic                  iFreeze,
   input  logic                  iFlush,
   output logic [INS_WIDTH-1:0]  oIMEM_IF_Instruction,
   output logic [SEL_WIDTH-1:0]  oData_Selection,
   output logic [PRED_WIDTH-1:0] oPredication,
   output logic [CNT_WIDTH-1:0]  oIssue_Count
);

`ifdef PE_ISSUE_REPEAT_EN
   localparam int EntryWidth = INS_WIDTH + SEL_WIDTH + PRED_WIDTH + REP_WIDTH;
`else
   localparam int EntryWidth = INS_WIDTH + SEL_WIDTH + PRED_WIDTH;
`endif

   logic [EntryWidth-1:0] wrData;
   logic [EntryWidth-1:0] head;
   logic [INS_WIDTH-1:0]  headIns;
   logic [SEL_WIDTH-1:0]  headSel;
   logic [PRED_WIDTH-1:0] headPred;
   logic [CNT_WIDTH-1:0]  count;
   issueState_e           state;
   logic                  push;
   logic                  canIssue;
   logic                  lastIssue;
   logic                  pop;

`ifdef PE_ISSUE_REPEAT_EN
   logic [REP_WIDTH-1:0] headRep;
   logic [REP_WIDTH-1:0] repLeft;
   logic [REP_WIDTH-1:0] remaining;
   logic                 repLoaded;

   assign wrData = {iCP_Issue_Instruction, iCP_Issue_Data_Sel, iCP_Issue_Predication, iCP_Issue_Repeat};
   assign {headIns, headSel, headPred, headRep} = head;

   // The head's repeat field seeds the down-counter on its first issue only.
   assign remaining = repLoaded ? repLeft : headRep;
   assign lastIssue = (remaining == '0);

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         repLeft   <= '0;
         repLoaded <= 1'b0;
      end else if (iFlush) begin
         repLeft   <= '0;
         repLoaded <= 1'b0;
      end else if (canIssue) begin
         if (lastIssue) begin
            repLeft   <= '0;
            repLoaded <= 1'b0;
         end else begin
            repLeft   <= remaining - 1'b1;
            repLoaded <= 1'b1;
         end
      end
   end
`else
   assign wrData = {iCP_Issue_Instruction, iCP_Issue_Data_Sel, iCP_Issue_Predication};
   assign {headIns, headSel, headPred} = head;
   assign lastIssue = 1'b1;
`endif

   assign state           = issueState(int'(count), FIFO_DEPTH);
   assign oCP_Issue_Ready = (state != ISSUE_FULL);
   assign push            = iCP_Issue_Valid && oCP_Issue_Ready && !iFlush;
   assign canIssue        = !iFreeze && !iFlush && (state != ISSUE_EMPTY);
   assign pop             = canIssue && lastIssue;
   assign oIssue_Count    = count;

   pe_issue_fifo #(
      .WIDTH     (EntryWidth),
      .DEPTH     (FIFO_DEPTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) uFifo (
      .iClk     (iClk),
      .iReset_n (iReset_n),
      .iPush    (push),
      .iPop     (pop),
      .iFlush   (iFlush),
      .iWrData  (wrData),
      .oHead    (head),
      .oCount   (count)
   );

   // Output registers: flush forces a NOP, freeze holds, otherwise head or a NOP bubble.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         oIMEM_IF_Instruction <= INS_WIDTH'(DEF_PE_NOP_INS);
         oData_Selection      <= '0;
         oPredication         <= '0;
      end else if (iFlush) begin
         oIMEM_IF_Instruction <= INS_WIDTH'(DEF_PE_NOP_INS);
         oData_Selection      <= '0;
         oPredication         <= '0;
      end else if (!iFreeze) begin
         if (state != ISSUE_EMPTY) begin
            oIMEM_IF_Instruction <= headIns;
            oData_Selection      <= headSel;
            oPredication         <= headPred;
         end else begin
            oIMEM_IF_Instruction <= INS_WIDTH'(DEF_PE_NOP_INS);
            oData_Selection      <= '0;
            oPredication         <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pe_array_ins_issue.sv
// Directed self-checking bench for pe_array_ins_issue; repeat tests run when PE_ISSUE_REPEAT_EN is defined.
module tb_pe_array_ins_issue;
   import pe_array_ins_issue_pkg::*;

   logic        iClk = 1'b0;
   logic        iReset_n;
   logic        iCP_Issue_Valid;
   logic        oCP_Issue_Ready;
   logic [19:0] iCP_Issue_Instruction;
   logic [2:0]  iCP_Issue_Data_Sel;
   logic [1:0]  iCP_Issue_Predication;
   logic [3:0]  iCP_Issue_Repeat;
   logic        iFreeze;
   logic        iFlush;
   logic [19:0] oIMEM_IF_Instruction;
   logic [2:0]  oData_Selection;
   logic [1:0]  oPredication;
   logic [2:0]  oIssue_Count;

   int checkCount = 0;
   int errorCount = 0;

   pe_array_ins_issue #(
      .INS_WIDTH  (20),
      .FIFO_DEPTH (4),
      .CNT_WIDTH  (3)
   ) dut (
      .iClk                  (iClk),
      .iReset_n              (iReset_n),
      .iCP_Issue_Valid       (iCP_Issue_Valid),
      .oCP_Issue_Ready       (oCP_Issue_Ready),
      .iCP_Issue_Instruction (iCP_Issue_Instruction),
      .iCP_Issue_Data_Sel    (iCP_Issue_Data_Sel),
      .iCP_Issue_Predication (iCP_Issue_Predication),
`ifdef PE_ISSUE_REPEAT_EN
      .iCP_Issue_Repeat      (iCP_Issue_Repeat),
`endif
      .iFreeze               (iFreeze),
      .iFlush                (iFlush),
      .oIMEM_IF_Instruction  (oIMEM_IF_Instruction),
      .oData_Selection       (oData_Selection),
      .oPredication          (oPredication),
      .oIssue_Count          (oIssue_Count)
   );

   always #5 iClk = ~iClk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [19:0] ins, input logic [2:0] sel,
                                input logic [1:0] pred, input logic freeze, input logic flush);
      iCP_Issue_Valid       = valid;
      iCP_Issue_Instruction = ins;
      iCP_Issue_Data_Sel    = sel;
      iCP_Issue_Predication = pred;
      iFreeze               = freeze;
      iFlush                = flush;
   endtask

   // Advance one active edge and settle just after it.
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   initial begin
      iReset_n         = 1'b0;
      iCP_Issue_Repeat = 4'd0;
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 0, 0);
      #12;
      iReset_n = 1'b1;
      checkOutput("resetInstr", 32'(oIMEM_IF_Instruction), 32'h0);
      checkOutput("resetCount", 32'(oIssue_Count), 32'd0);
      checkOutput("resetReady", 32'(oCP_Issue_Ready), 32'd1);

      // Single push reaches outputs one edge after it is accepted.
      applyStimulus(1, 20'h0A5A5, 3'd3, 2'd2, 0, 0);
      tick();
      checkOutput("latNopBefore", 32'(oIMEM_IF_Instruction), 32'h0);
      checkOutput("latCount1", 32'(oIssue_Count), 32'd1);
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 0, 0);
      tick();
      checkOutput("latInstr", 32'(oIMEM_IF_Instruction), 32'h0A5A5);
      checkOutput("latSel", 32'(oData_Selection), 32'd3);
      checkOutput("latPred", 32'(oPredication), 32'd2);
      checkOutput("latCount0", 32'(oIssue_Count), 32'd0);
      tick();
      checkOutput("bubbleNop", 32'(oIMEM_IF_Instruction), 32'h0);

      // Fill while frozen; the fifth offer is refused.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1, 20'(i * 32'h11111), 3'(i), 2'(i % 4), 1, 0);
         tick();
         if (i == 4) begin
            checkOutput("fullReady", 32'(oCP_Issue_Ready), 32'd0);
            checkOutput("fullCount", 32'(oIssue_Count), 32'd4);
         end
      end
      checkOutput("fullHeldCount", 32'(oIssue_Count), 32'd4);
      checkOutput("frozenHoldNop", 32'(oIMEM_IF_Instruction), 32'h0);

      // Drain from full with Valid held: first edge pops only, then push+pop each edge.
      applyStimulus(1, 20'h55555, 3'd5, 2'd1, 0, 0);
      tick();
      checkOutput("drain1Instr", 32'(oIMEM_IF_Instruction), 32'h11111);
      checkOutput("drain1Count", 32'(oIssue_Count), 32'd3);
      checkOutput("drain1Ready", 32'(oCP_Issue_Ready), 32'd1);
      tick();
      checkOutput("drain2Instr", 32'(oIMEM_IF_Instruction), 32'h22222);
      checkOutput("drain2Count", 32'(oIssue_Count), 32'd3);
      applyStimulus(1, 20'h66666, 3'd6, 2'd2, 0, 0);
      tick();
      checkOutput("drain3Instr", 32'(oIMEM_IF_Instruction), 32'h33333);
      checkOutput("drain3Count", 32'(oIssue_Count), 32'd3);
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 0, 0);
      tick();
      checkOutput("drain4Instr", 32'(oIMEM_IF_Instruction), 32'h44444);
      checkOutput("drain4Sel", 32'(oData_Selection), 32'd4);
      checkOutput("drain4Count", 32'(oIssue_Count), 32'd2);

      // Flush beats a concurrent push.
      applyStimulus(1, 20'h77777, 3'd7, 2'd3, 0, 1);
      tick();
      checkOutput("flushCount", 32'(oIssue_Count), 32'd0);
      checkOutput("flushInstr", 32'(oIMEM_IF_Instruction), 32'h0);
      checkOutput("flushSel", 32'(oData_Selection), 32'd0);
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 0, 0);
      tick();
      checkOutput("flushDropInstr", 32'(oIMEM_IF_Instruction), 32'h0);
      checkOutput("flushDropCount", 32'(oIssue_Count), 32'd0);

`ifdef PE_ISSUE_REPEAT_EN
      // Repeat=2: three unfrozen issues, a frozen cycle in between does not count.
      iCP_Issue_Repeat = 4'd2;
      applyStimulus(1, 20'h0BEEF, 3'd1, 2'd1, 0, 0);
      tick();
      iCP_Issue_Repeat = 4'd0;
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 0, 0);
      tick();
      checkOutput("rep1", 32'(oIMEM_IF_Instruction), 32'h0BEEF);
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 1, 0);
      tick();
      checkOutput("repFrozen", 32'(oIMEM_IF_Instruction), 32'h0BEEF);
      checkOutput("repFrozenCount", 32'(oIssue_Count), 32'd1);
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 0, 0);
      tick();
      checkOutput("rep2", 32'(oIMEM_IF_Instruction), 32'h0BEEF);
      checkOutput("rep2Count", 32'(oIssue_Count), 32'd1);
      tick();
      checkOutput("rep3", 32'(oIMEM_IF_Instruction), 32'h0BEEF);
      checkOutput("rep3Count", 32'(oIssue_Count), 32'd0);
      tick();
      checkOutput("repDoneNop", 32'(oIMEM_IF_Instruction), 32'h0);
`endif

      // Queue three entries behind a live output, then reset asynchronously mid-cycle.
      applyStimulus(1, 20'h0A001, 3'd1, 2'd1, 0, 0);
      tick();
      applyStimulus(1, 20'h0A002, 3'd2, 2'd2, 0, 0);
      tick();
      applyStimulus(1, 20'h0A003, 3'd3, 2'd3, 1, 0);
      tick();
      applyStimulus(1, 20'h0A004, 3'd4, 2'd0, 1, 0);
      tick();
      checkOutput("preResetCount", 32'(oIssue_Count), 32'd3);
      checkOutput("preResetInstr", 32'(oIMEM_IF_Instruction), 32'h0A001);
      applyStimulus(0, 20'h0, 3'd0, 2'd0, 0, 0);
      #2;
      iReset_n = 1'b0;
      #1;
      checkOutput("asyncResetInstr", 32'(oIMEM_IF_Instruction), 32'h0);
      checkOutput("asyncResetSel", 32'(oData_Selection), 32'd0);
      checkOutput("asyncResetCount", 32'(oIssue_Count), 32'd0);
      checkOutput("asyncResetReady", 32'(oCP_Issue_Ready), 32'd1);
      iReset_n = 1'b1;
      tick();
      checkOutput("postResetNop", 32'(oIMEM_IF_Instruction), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
